traffic_light_sequencer: RTL and testbench



---
 rtl/traffic_light_sequencer.sv | 174 +++++++++++++++++
 tb/tb_traffic_light_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
// Two-direction intersection sequencer with pedestrian walk, emergency hold and night flash.
// Optional TLS_WALK_COUNTDOWN_EN adds a walkCountdown output showing remaining walk cycles.
module traffic_light_sequencer #(
    parameter int CNT_WIDTH    = 8,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 6,
    parameter int FLASH_TICKS  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    output logic [2:0]           nsLight,
    output logic [2:0]           ewLight,
    output logic                 walk,
    output logic [2:0]           stateOut
`ifdef TLS_WALK_COUNTDOWN_EN
    ,
    output logic [CNT_WIDTH-1:0] walkCountdown
`endif
);

    typedef enum logic [2:0] {
        ALL_RED     = 3'd0,
        NS_G        = 3'd1,
        NS_Y        = 3'd2,
        EW_G        = 3'd3,
        EW_Y        = 3'd4,
        PED_WALK    = 3'd5,
        EMG_HOLD    = 3'd6,
        NIGHT_FLASH = 3'd7
    } state_e;

    localparam logic [1:0] MODE_DAY   = 2'b00;
    localparam logic [1:0] MODE_NIGHT = 2'b01;
    localparam logic [1:0] MODE_PED   = 2'b10;
    localparam logic [1:0] MODE_EMG   = 2'b11;

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] GREEN_LD  = CNT_WIDTH'(GREEN_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] YELLOW_LD = CNT_WIDTH'(YELLOW_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] ALLRED_LD = CNT_WIDTH'(ALLRED_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] WALK_LD   = CNT_WIDTH'(WALK_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] FLASH_LD  = CNT_WIDTH'(FLASH_TICKS - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 next_dir_q, next_dir_d;
    logic                 ped_pending_q, ped_pending_d;
    logic                 flash_phase_q, flash_phase_d;

    function automatic logic [2:0] ns_lamp(input state_e s, input logic fp);
        case (s)
            NS_G:        ns_lamp = 3'b001;
            NS_Y:        ns_lamp = 3'b010;
            NIGHT_FLASH: ns_lamp = fp ? 3'b000 : 3'b010;
            default:     ns_lamp = 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp(input state_e s, input logic fp);
        case (s)
            EW_G:        ew_lamp = 3'b001;
            EW_Y:        ew_lamp = 3'b010;
            NIGHT_FLASH: ew_lamp = fp ? 3'b000 : 3'b100;
            default:     ew_lamp = 3'b100;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q - ONE;
        next_dir_d    = next_dir_q;
        ped_pending_d = ped_pending_q | (mode == MODE_PED);
        flash_phase_d = flash_phase_q;
        case (state_q)
            ALL_RED: begin
                if (mode == MODE_EMG) begin
                    state_d = EMG_HOLD;
                    cnt_d   = ALLRED_LD;
                end else if (cnt_q == '0) begin
                    // A request being served wins over a fresh request in the same cycle.
                    if (ped_pending_q) begin
                        state_d       = PED_WALK;
                        cnt_d         = WALK_LD;
                        ped_pending_d = 1'b0;
                    end else if (mode == MODE_NIGHT) begin
                        state_d       = NIGHT_FLASH;
                        cnt_d         = FLASH_LD;
                        flash_phase_d = 1'b0;
                    end else begin
                        state_d = next_dir_q ? EW_G : NS_G;
                        cnt_d   = GREEN_LD;
                    end
                end
            end
            NS_G, EW_G: begin
                if (mode == MODE_EMG || cnt_q == '0) begin
                    state_d = (state_q == NS_G) ? NS_Y : EW_Y;
                    cnt_d   = YELLOW_LD;
                end
            end
            NS_Y, EW_Y: begin
                if (cnt_q == '0) begin
                    state_d    = (mode == MODE_EMG) ? EMG_HOLD : ALL_RED;
                    cnt_d      = ALLRED_LD;
                    next_dir_d = (state_q == NS_Y);
                end
            end
            PED_WALK: begin
                if (mode == MODE_EMG) begin
                    state_d = EMG_HOLD;
                    cnt_d   = ALLRED_LD;
                end else if (cnt_q == '0) begin
                    state_d = ALL_RED;
                    cnt_d   = ALLRED_LD;
                end
            end
            EMG_HOLD: begin
                // Counter parked at the all-red load so the exit gets a full clearance.
                cnt_d = ALLRED_LD;
                if (mode != MODE_EMG) state_d = ALL_RED;
            end
            NIGHT_FLASH: begin
                if (mode == MODE_EMG) begin
                    state_d = EMG_HOLD;
                    cnt_d   = ALLRED_LD;
                end else if (mode == MODE_DAY || mode == MODE_PED) begin
                    state_d = ALL_RED;
                    cnt_d   = ALLRED_LD;
                end else if (cnt_q == '0) begin
                    flash_phase_d = ~flash_phase_q;
                    cnt_d         = FLASH_LD;
                end
            end
            default: begin
                state_d = ALL_RED;
                cnt_d   = ALLRED_LD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ALL_RED;
            cnt_q         <= ALLRED_LD;
            next_dir_q    <= 1'b0;
            ped_pending_q <= 1'b0;
            flash_phase_q <= 1'b0;
            nsLight       <= 3'b100;
            ewLight       <= 3'b100;
            walk          <= 1'b0;
            stateOut      <= 3'd0;
`ifdef TLS_WALK_COUNTDOWN_EN
            walkCountdown <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
            flash_phase_q <= flash_phase_d;
            nsLight       <= ns_lamp(state_d, flash_phase_d);
            ewLight       <= ew_lamp(state_d, flash_phase_d);
            walk          <= (state_d == PED_WALK);
            stateOut      <= state_d;
`ifdef TLS_WALK_COUNTDOWN_EN
            walkCountdown <= (state_d == PED_WALK) ? cnt_d + ONE : '0;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench: a phase/age reference model predicts each cycle's outputs,
// a monitor compares the DUT after every rising edge.
module tb_traffic_light_sequencer;

    localparam int CW = 8;
    localparam int G  = 8;
    localparam int Y  = 3;
    localparam int AR = 2;
    localparam int W  = 6;
    localparam int F  = 4;

`ifdef TLS_WALK_COUNTDOWN_EN
    localparam int XW = 10 + CW;
`else
    localparam int XW = 10;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic [2:0]    nsLight, ewLight, stateOut;
    logic          walk;
`ifdef TLS_WALK_COUNTDOWN_EN
    logic [CW-1:0] walkCountdown;
`endif

    traffic_light_sequencer #(
        .CNT_WIDTH(CW), .GREEN_TICKS(G), .YELLOW_TICKS(Y),
        .ALLRED_TICKS(AR), .WALK_TICKS(W), .FLASH_TICKS(F)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .nsLight(nsLight), .ewLight(ewLight), .walk(walk), .stateOut(stateOut)
`ifdef TLS_WALK_COUNTDOWN_EN
        , .walkCountdown(walkCountdown)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [XW-1:0] sb[$];

    // Reference model: phase number, cycles spent in it so far (1-based), and flags.
    int m_ph, m_age;
    bit m_dir, m_ped, m_flash;

    function automatic void model_reset();
        m_ph = 0; m_age = 1; m_dir = 0; m_ped = 0; m_flash = 0;
    endfunction

    function automatic void go(int p);
        m_ph = p; m_age = 1;
        if (p == 7) m_flash = 0;
    endfunction

    function automatic void model_step(logic [1:0] m);
        bit ped_next;
        ped_next = m_ped || (m == 2'b10);
        case (m_ph)
            0: if (m == 2'b11) go(6);
               else if (m_age == AR) begin
                   if (m_ped) begin go(5); ped_next = 0; end
                   else if (m == 2'b01) go(7);
                   else go(m_dir ? 3 : 1);
               end else m_age++;
            1, 3: if (m == 2'b11 || m_age == G) go(m_ph + 1); else m_age++;
            2, 4: if (m_age == Y) begin
                      m_dir = (m_ph == 2);
                      go(m == 2'b11 ? 6 : 0);
                  end else m_age++;
            5: if (m == 2'b11) go(6); else if (m_age == W) go(0); else m_age++;
            6: if (m != 2'b11) go(0);
            default: if (m == 2'b11) go(6);
               else if (m == 2'b00 || m == 2'b10) go(0);
               else if (m_age == F) begin m_flash = !m_flash; m_age = 1; end
               else m_age++;
        endcase
        m_ped = ped_next;
    endfunction

    function automatic logic [XW-1:0] model_out();
        logic [2:0] ns, ew;
        logic [XW-1:0] r;
        ns = 3'b100; ew = 3'b100;
        if (m_ph == 1) ns = 3'b001;
        if (m_ph == 2) ns = 3'b010;
        if (m_ph == 3) ew = 3'b001;
        if (m_ph == 4) ew = 3'b010;
        if (m_ph == 7) begin
            ns = m_flash ? 3'b000 : 3'b010;
            ew = m_flash ? 3'b000 : 3'b100;
        end
        r = '0;
        r[9:0] = {3'(m_ph), ns, ew, (m_ph == 5)};
`ifdef TLS_WALK_COUNTDOWN_EN
        r[XW-1:10] = (m_ph == 5) ? CW'(W - m_age + 1) : '0;
`endif
        return r;
    endfunction

    function automatic logic [XW-1:0] dut_out();
        logic [XW-1:0] r;
        r = '0;
        r[9:0] = {stateOut, nsLight, ewLight, walk};
`ifdef TLS_WALK_COUNTDOWN_EN
        r[XW-1:10] = walkCountdown;
`endif
        return r;
    endfunction

    // Monitor: one expectation is consumed after each rising edge that follows a push.
    initial begin
        logic [XW-1:0] exp_v, got_v;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp_v = sb.pop_front();
                got_v = dut_out();
                n_cmp++;
                if (got_v !== exp_v) begin
                    n_bad++;
                    $display("FAIL cycle_out t=%0t: got state=%0d ns=%b ew=%b walk=%b ext=%0h, expected state=%0d ns=%b ew=%b walk=%b ext=%0h",
                             $time, got_v[9:7], got_v[6:4], got_v[3:1], got_v[0], got_v >> 10,
                             exp_v[9:7], exp_v[6:4], exp_v[3:1], exp_v[0], exp_v >> 10);
                end
                n_cmp++;
                if ((nsLight inside {3'b001, 3'b010}) && (ewLight inside {3'b001, 3'b010})) begin
                    n_bad++;
                    $display("FAIL lamp_safety t=%0t: got ns=%b ew=%b, expected at most one non-red lit", $time, nsLight, ewLight);
                end
            end
        end
    end

    // Every task starts and ends just at a falling edge.
    task automatic cycle(input logic [1:0] m);
        mode = m;
        model_step(m);
        sb.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] m, input int n);
        for (int i = 0; i < n; i++) cycle(m);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if (nsLight !== 3'b100 || ewLight !== 3'b100 || walk !== 1'b0 || stateOut !== 3'd0) begin
            n_bad++;
            $display("FAIL async_reset t=%0t: got ns=%b ew=%b walk=%b state=%0d, expected 100 100 0 0",
                     $time, nsLight, ewLight, walk, stateOut);
        end
`ifdef TLS_WALK_COUNTDOWN_EN
        n_cmp++;
        if (walkCountdown !== '0) begin
            n_bad++;
            $display("FAIL reset_countdown: got %0d, expected 0", walkCountdown);
        end
`endif
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int age, input logic [1:0] m);
        for (int i = 0; i < 200; i++) begin
            if (m_ph == ph && m_age == age) return;
            cycle(m);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_phase: got no phase %0d age %0d within 200 cycles, required reachable", ph, age);
    endtask

    initial begin
        rst  = 1'b1;
        mode = 2'b00;
        @(negedge clk);
        do_reset();

        // Day cycling, then a pedestrian pulse in the 3rd cycle of NS green.
        run(2'b00, 60);
        wait_phase(1, 3, 2'b00);
        cycle(2'b10);
        wait_phase(3, 1, 2'b00);
        // Emergency in the 2nd cycle of EW green.
        wait_phase(3, 2, 2'b00);
        run(2'b11, 13);
        run(2'b00, 12);
        // Night flash from reset.
        do_reset();
        run(2'b01, 30);
        run(2'b00, 12);
        // Reset in the 2nd cycle of EW yellow with a request pending.
        wait_phase(3, 2, 2'b00);
        cycle(2'b10);
        wait_phase(4, 2, 2'b00);
        do_reset();
        run(2'b00, 30);

        // Randomised mode runs with occasional resets.
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) do_reset();
            else if (r < 55) run(2'b00, int'($urandom_range(1, 20)));
            else if (r < 70) run(2'b10, int'($urandom_range(1, 2)));
            else if (r < 85) run(2'b01, int'($urandom_range(3, 30)));
            else run(2'b11, int'($urandom_range(1, 12)));
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d outstanding expectations, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
